// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter that time-shares one serial sequence detector between two word requesters.
// Optional SEQ_ARB_STATS_EN adds a saturating total_hits accumulator.
module seq_detect_arbiter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] word0,
    input  logic [WIDTH-1:0] word1,
    output logic             ack0,
    output logic             ack1,
    output logic [CW-1:0]    hits,
    output logic             busy,
    output logic             det_x,
    output logic             det_clear,
    input  logic             det_y
`ifdef SEQ_ARB_STATS_EN
    ,
    output logic [15:0]      total_hits
`endif
);

    localparam int IW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    logic [2:0]       state, state_n;
    logic [WIDTH-1:0] word_q;
    logic             port_q, last, grant;
    logic [IW-1:0]    idx, idx_n;
    logic [CW-1:0]    cnt, cnt_n, y_ext;

    assign y_ext = {{(CW-1){1'b0}}, det_y};
    // last==1 after reset, so port 0 wins the first tie
    assign grant = (req0 && req1) ? ~last : req1;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        case (state)
            S_IDLE:  if (req0 || req1) state_n = S_CLEAR;
            S_CLEAR: begin
                state_n = S_SHIFT;
                idx_n   = IDX_TOP;
                cnt_n   = '0;
            end
            S_SHIFT: begin
                // first SHIFT cycle still shows the cleared detector
                if (idx != IDX_TOP) cnt_n = cnt + y_ext;
                if (idx == '0) state_n = S_DRAIN;
                else           idx_n   = idx - 1'b1;
            end
            S_DRAIN: begin
                cnt_n   = cnt + y_ext;
                state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they align with the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= IDX_TOP;
            cnt       <= '0;
            word_q    <= '0;
            port_q    <= 1'b0;
            last      <= 1'b1;
            busy      <= 1'b0;
            det_clear <= 1'b1;
            det_x     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            hits      <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            if (state == S_IDLE && (req0 || req1)) begin
                word_q <= grant ? word1 : word0;
                port_q <= grant;
            end
            if (state == S_DONE) last <= port_q;
            busy      <= (state_n != S_IDLE);
            det_clear <= (state_n == S_IDLE) || (state_n == S_CLEAR);
            det_x     <= (state_n == S_SHIFT) && word_q[idx_n];
            ack0      <= (state_n == S_DONE) && !port_q;
            ack1      <= (state_n == S_DONE) && port_q;
            hits      <= (state_n == S_DONE) ? cnt_n : '0;
        end
    end

`ifdef SEQ_ARB_STATS_EN
    logic [16:0] sum;
    assign sum = {1'b0, total_hits} + 17'(hits);

    always_ff @(posedge clk) begin
        if (reset)                total_hits <= '0;
        else if (state == S_DONE) total_hits <= sum[16] ? 16'hFFFF : sum[15:0];
    end
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Bench for seq_detect_arbiter: transaction-timeline model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic and resets.
module tb_seq_detect_arbiter;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]  word0 = '0, word1 = '0;
    logic          ack0, ack1, busy, det_x, det_clear;
    logic [CW-1:0] hits;
    logic          det_y = 1'b0, dprev = 1'b0;
`ifdef SEQ_ARB_STATS_EN
    logic [15:0]   total_hits;
`endif

    seq_detect_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .word0(word0), .word1(word1), .ack0(ack0), .ack1(ack1),
        .hits(hits), .busy(busy), .det_x(det_x), .det_clear(det_clear),
        .det_y(det_y)
`ifdef SEQ_ARB_STATS_EN
        , .total_hits(total_hits)
`endif
    );

    always #5 clk = ~clk;

    // detector: y one cycle after two consecutive 1s on x
    always @(posedge clk) begin
        if (det_clear) begin
            det_y <= 1'b0;
            dprev <= 1'b0;
        end else begin
            det_y <= dprev & det_x;
            dprev <= det_x;
        end
    end

    int n_cmp = 0, n_err = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pairs(input logic [W-1:0] w);
        int n = 0;
        for (int i = 0; i < W - 1; i++) if (w[i] && w[i+1]) n++;
        return n;
    endfunction

    // timeline model: mk = cycles since grant (1..W+3), -1 when idle
    int        mk = -1, mhits = 0, mtot = 0;
    bit        mptr = 1'b1, mport = 1'b0;
    logic [W-1:0] mword = '0;
    logic [31:0] e_v, a_v;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mk = -1; mptr = 1'b1; mtot = 0;
        end else if (mk == W + 3) begin
            mtot = (mtot + mhits > 65535) ? 65535 : mtot + mhits;
            mptr = mport;
            mk   = -1;
        end else if (mk >= 1) begin
            mk++;
        end else if (req0 || req1) begin
            mport = (req0 && req1) ? !mptr : req1;
            mword = mport ? word1 : word0;
            mhits = pairs(mword);
            mk    = 1;
        end
        #1;
        e_v = '0;
        e_v[CW+4] = (mk != -1);
        e_v[CW+3] = (mk == -1) || (mk == 1);
        e_v[CW+2] = (mk >= 2 && mk <= W + 1) ? mword[W+1-mk] : 1'b0;
        e_v[CW+1] = (mk == W + 3) && !mport;
        e_v[CW]   = (mk == W + 3) && mport;
        e_v[CW-1:0] = (mk == W + 3) ? CW'(mhits) : '0;
        a_v = 32'({busy, det_clear, det_x, ack0, ack1, hits});
        chk("cycle_outputs", a_v, e_v);
`ifdef SEQ_ARB_STATS_EN
        chk("cycle_total_hits", 32'(total_hits), 32'(mtot));
`endif
    end

    int lp[$], lc[$], lh[$];
    int t0 = 0, idle_cnt = 0;
    logic [W-1:0] xseq = '0;

    task automatic clr_log();
        lp.delete(); lc.delete(); lh.delete();
        idle_cnt = 0; xseq = '0;
    endtask

    // Waits for nacks acknowledges, dropping req on ack; rearm re-raises it one cycle later.
    task automatic serve(input int nacks, input bit rearm, input int maxcyc);
        int got = 0, n = 0;
        bit p0 = 0, p1 = 0;
        while (got < nacks && n < maxcyc) begin
            @(negedge clk);
            n++;
            if (got > 0 && !busy) idle_cnt++;
            if (cyc - t0 >= 2 && cyc - t0 <= W + 1) xseq = {xseq[W-2:0], det_x};
            if (ack0) begin
                lp.push_back(0); lc.push_back(cyc); lh.push_back(int'(hits));
                req0 = 1'b0; p0 = rearm; got++;
            end else if (p0) begin
                req0 = 1'b1; p0 = 0;
            end
            if (ack1) begin
                lp.push_back(1); lc.push_back(cyc); lh.push_back(int'(hits));
                req1 = 1'b0; p1 = rearm; got++;
            end else if (p1) begin
                req1 = 1'b1; p1 = 0;
            end
        end
        if (got < nacks) chk("ack_timeout", 32'(got), 32'(nacks));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef SEQ_ARB_STATS_EN
    logic [W-1:0] sw[3] = '{8'hFF, 8'h0F, 8'h00};
    int           se[3] = '{7, 10, 10};
`endif

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_det_clear", 32'(det_clear), 32'd1);
        chk("rst_acks_x", 32'({ack0, ack1, det_x}), 32'd0);
        chk("rst_hits", 32'(hits), 32'd0);
        reset = 1'b0;

        // single request: latency, count and serial order
        word0 = 8'b0110_1110; req0 = 1'b1; t0 = cyc; clr_log();
        serve(1, 0, 40);
        chk("t1_port", 32'(lp[0]), 32'd0);
        chk("t1_latency", 32'(lc[0] - t0), 32'd11);
        chk("t1_hits", 32'(lh[0]), 32'd3);
        chk("t1_xseq", 32'(xseq), 32'b0110_1110);

        // simultaneous requests after reset: port 0 first
        do_reset();
        word0 = 8'hFF; word1 = 8'h00; req0 = 1'b1; req1 = 1'b1; t0 = cyc; clr_log();
        serve(2, 0, 60);
        chk("t2_first_port", 32'(lp[0]), 32'd0);
        chk("t2_first_hits", 32'(lh[0]), 32'd7);
        chk("t2_first_latency", 32'(lc[0] - t0), 32'd11);
        chk("t2_second_port", 32'(lp[1]), 32'd1);
        chk("t2_second_hits", 32'(lh[1]), 32'd0);
        chk("t2_spacing", 32'(lc[1] - lc[0]), 32'd12);

        // continuous contention alternates, one idle cycle between words
        word0 = 8'h3C; word1 = 8'h81; req0 = 1'b1; req1 = 1'b1; t0 = cyc; clr_log();
        serve(4, 1, 100);
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) chk("t3_order", 32'(lp[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) chk("t3_spacing", 32'(lc[i] - lc[i-1]), 32'd12);
        chk("t3_idle_cycles", 32'(idle_cnt), 32'd3);

        // reset during SHIFT of a port-1 word, then reissue
        @(negedge clk);
        word1 = 8'hF0; req1 = 1'b1; t0 = cyc;
        repeat (5) @(negedge clk);
        reset = 1'b1; req1 = 1'b0;
        @(negedge clk);
        chk("t4_after_reset", 32'({busy, det_clear, ack1, hits}), 32'({1'b0, 1'b1, 1'b0, {CW{1'b0}}}));
        reset = 1'b0; req1 = 1'b1; t0 = cyc; clr_log();
        serve(1, 0, 40);
        chk("t4_reissue_port", 32'(lp[0]), 32'd1);
        chk("t4_reissue_hits", 32'(lh[0]), 32'd3);

        // trailing 1s of one word must not leak into the next
        @(negedge clk);
        word0 = 8'b1010_1011; req0 = 1'b1; clr_log();
        serve(1, 0, 40);
        @(negedge clk);
        word0 = 8'hFF; req0 = 1'b1;
        serve(1, 0, 40);
        chk("t5_hits_first", 32'(lh[0]), 32'd1);
        chk("t5_hits_second", 32'(lh[1]), 32'd7);

`ifdef SEQ_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            word0 = sw[i]; req0 = 1'b1; clr_log();
            serve(1, 0, 40);
            @(negedge clk);
            chk("stats_total", 32'(total_hits), 32'(se[i]));
        end
        do_reset();
        chk("stats_reset", 32'(total_hits), 32'd0);
`endif

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            reset = ($urandom_range(120) == 0);
            if (req0 && ack0) req0 = 1'b0;
            else if (!req0 && $urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: word0 = 8'hFF;
                    1: word0 = 8'h00;
                    default: word0 = W'($urandom);
                endcase
                req0 = 1'b1;
            end
            if (req1 && ack1) req1 = 1'b0;
            else if (!req1 && $urandom_range(3) == 0) begin
                word1 = ($urandom_range(3) == 0) ? 8'hFF : W'($urandom);
                req1 = 1'b1;
            end
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
